// File: rtl/scan_chain_loader_if.sv
// Code-word handshake between the hop controller (master) and the scan chain loader (slave).
interface scan_chain_loader_if #(
   parameter int DATA_WIDTH = 128
);
   logic [DATA_WIDTH-1:0] s_tdata;
   logic                  s_tvalid;
   logic                  s_tready;

   modport master (
      output s_tdata,
      output s_tvalid,
      input  s_tready
   );

   modport slave (
      input  s_tdata,
      input  s_tvalid,
      output s_tready
   );
endinterface

// File: rtl/scan_chain_loader.sv
// Shifts one code word into the tag chip scan chain using two-phase non-overlapping
// scan clocks, then pulses the parallel-load strobe and reports done.
module scan_chain_loader #(
   parameter int DATA_WIDTH = 128,
   parameter int NBITS      = 78,
   parameter int CNT_WIDTH  = 7,
   parameter int DIV        = 20,
   parameter int MSB_FIRST  = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   scan_chain_loader_if.slave   code_if,
   output logic                 scan_id,
   output logic                 scan_phi,
   output logic                 scan_phi_bar,
   output logic                 scan_data_in,
   output logic                 scan_load_chip,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] bit_cnt
);

   // One extra bit so the phase counter can also time the 2*DIV load strobe.
   localparam int PCW = $clog2(DIV) + 1;
   localparam logic [PCW-1:0]       PH_LAST   = PCW'(DIV - 1);
   localparam logic [PCW-1:0]       LOAD_LAST = PCW'(2 * DIV - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(NBITS);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(NBITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PHI,
      GAP,
      PHIB,
      LOAD,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [PCW-1:0]       phase_q, phase_d;
   logic [NBITS-1:0]     shift_q, shift_d;
   logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

   logic scan_id_q, scan_id_d;
   logic scan_phi_q, scan_phi_d;
   logic scan_phi_bar_q, scan_phi_bar_d;
   logic scan_data_in_q, scan_data_in_d;
   logic scan_load_chip_q, scan_load_chip_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic [DATA_WIDTH-1:0] tdata;
   logic                  unused_tdata;
   logic                  accept;
   logic                  phase_end;
   logic                  load_end;
   logic                  shifting_d;

   assign tdata        = code_if.s_tdata;
   assign unused_tdata = ^tdata;

   assign code_if.s_tready = (state_q == IDLE) && !clear;
   assign accept           = code_if.s_tvalid && code_if.s_tready;
   assign phase_end        = (phase_q == PH_LAST);
   assign load_end         = (phase_q == LOAD_LAST);

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q + 1'b1;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;

      if (clear) begin
         state_d   = IDLE;
         phase_d   = '0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               phase_d = '0;
               if (accept) begin
                  shift_d   = tdata[NBITS-1:0];
                  bit_cnt_d = '0;
                  state_d   = SETUP;
               end
            end
            SETUP: begin
               if (phase_end) begin
                  phase_d = '0;
                  state_d = PHI;
               end
            end
            PHI: begin
               if (phase_end) begin
                  phase_d = '0;
                  state_d = GAP;
               end
            end
            GAP: begin
               if (phase_end) begin
                  phase_d = '0;
                  state_d = PHIB;
               end
            end
            PHIB: begin
               if (phase_end) begin
                  phase_d = '0;
                  shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
                  if (bit_cnt_q != CNT_MAX) begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
                  state_d = (bit_cnt_q < CNT_LAST) ? SETUP : LOAD;
               end
            end
            LOAD: begin
               if (load_end) begin
                  phase_d = '0;
                  state_d = DONE;
               end
            end
            DONE: begin
               phase_d = '0;
               state_d = IDLE;
            end
            default: begin
               phase_d = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs decode the next state so they switch on the same edge as the state.
   always_comb begin
      shifting_d       = state_d inside {SETUP, PHI, GAP, PHIB};
      scan_id_d        = shifting_d;
      scan_phi_d       = (state_d == PHI);
      scan_phi_bar_d   = (state_d == PHIB);
      scan_data_in_d   = shifting_d &&
                         ((MSB_FIRST != 0) ? shift_d[NBITS-1] : shift_d[0]);
      scan_load_chip_d = (state_d == LOAD);
      busy_d           = (state_d != IDLE);
      done_d           = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= IDLE;
         phase_q          <= '0;
         shift_q          <= '0;
         bit_cnt_q        <= '0;
         scan_id_q        <= 1'b0;
         scan_phi_q       <= 1'b0;
         scan_phi_bar_q   <= 1'b0;
         scan_data_in_q   <= 1'b0;
         scan_load_chip_q <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         phase_q          <= phase_d;
         shift_q          <= shift_d;
         bit_cnt_q        <= bit_cnt_d;
         scan_id_q        <= scan_id_d;
         scan_phi_q       <= scan_phi_d;
         scan_phi_bar_q   <= scan_phi_bar_d;
         scan_data_in_q   <= scan_data_in_d;
         scan_load_chip_q <= scan_load_chip_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
      end
   end

   assign scan_id        = scan_id_q;
   assign scan_phi       = scan_phi_q;
   assign scan_phi_bar   = scan_phi_bar_q;
   assign scan_data_in   = scan_data_in_q;
   assign scan_load_chip = scan_load_chip_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign bit_cnt        = bit_cnt_q;

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: three configurations checked cycle by cycle against
// a timing-formula model of the expected scan waveform.
module tb_scan_chain_loader;
   localparam int DW = 128;
   localparam int CW = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          clear  [3];
   logic [DW-1:0] tdata  [3];
   logic          tvalid [3];

   logic [6:0]    o_a, o_b, o_c;
   logic [CW-1:0] cnt_a, cnt_b, cnt_c;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   scan_chain_loader_if #(.DATA_WIDTH(DW)) if_a ();
   scan_chain_loader_if #(.DATA_WIDTH(DW)) if_b ();
   scan_chain_loader_if #(.DATA_WIDTH(DW)) if_c ();

   assign if_a.s_tdata  = tdata[0];
   assign if_a.s_tvalid = tvalid[0];
   assign if_b.s_tdata  = tdata[1];
   assign if_b.s_tvalid = tvalid[1];
   assign if_c.s_tdata  = tdata[2];
   assign if_c.s_tvalid = tvalid[2];

   scan_chain_loader #(.DATA_WIDTH(DW), .NBITS(4), .CNT_WIDTH(CW), .DIV(2), .MSB_FIRST(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .clear(clear[0]), .code_if(if_a),
      .scan_id(o_a[6]), .scan_phi(o_a[5]), .scan_phi_bar(o_a[4]), .scan_data_in(o_a[3]),
      .scan_load_chip(o_a[2]), .busy(o_a[1]), .done(o_a[0]), .bit_cnt(cnt_a));

   scan_chain_loader #(.DATA_WIDTH(DW), .NBITS(4), .CNT_WIDTH(CW), .DIV(2), .MSB_FIRST(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .clear(clear[1]), .code_if(if_b),
      .scan_id(o_b[6]), .scan_phi(o_b[5]), .scan_phi_bar(o_b[4]), .scan_data_in(o_b[3]),
      .scan_load_chip(o_b[2]), .busy(o_b[1]), .done(o_b[0]), .bit_cnt(cnt_b));

   scan_chain_loader #(.DATA_WIDTH(DW), .NBITS(78), .CNT_WIDTH(CW), .DIV(20), .MSB_FIRST(1)) dut_c (
      .clk(clk), .reset_n(reset_n), .clear(clear[2]), .code_if(if_c),
      .scan_id(o_c[6]), .scan_phi(o_c[5]), .scan_phi_bar(o_c[4]), .scan_data_in(o_c[3]),
      .scan_load_chip(o_c[2]), .busy(o_c[1]), .done(o_c[0]), .bit_cnt(cnt_c));

   // Vector layout: {ready, id, phi, phi_bar, data, load, busy, done, bit_cnt[6:0]}
   localparam logic [14:0] IDLE_V = 15'h4000;

   function automatic logic [14:0] get_obs(input int sel);
      case (sel)
         0:       return {if_a.s_tready, o_a, cnt_a};
         1:       return {if_b.s_tready, o_b, cnt_b};
         default: return {if_c.s_tready, o_c, cnt_c};
      endcase
   endfunction

   // Expected outputs t cycles after the handshake cycle, from the timing rules.
   function automatic logic [14:0] model(input int t, input int n, input int div,
                                         input logic [DW-1:0] w, input bit msb,
                                         input int prev_cnt);
      logic rdy, id, phi, phib, din, load, busy, done;
      int cnt, k, ph;
      rdy = 0; id = 0; phi = 0; phib = 0; din = 0; load = 0; busy = 0; done = 0;
      cnt = n;
      if (t <= 0) begin
         rdy = 1;
         cnt = prev_cnt;
      end else if (t <= 4 * n * div) begin
         k    = (t - 1) / (4 * div);
         ph   = ((t - 1) % (4 * div)) / div;
         id   = 1;
         phi  = (ph == 1);
         phib = (ph == 3);
         din  = msb ? w[n - 1 - k] : w[k];
         busy = 1;
         cnt  = k;
      end else if (t <= (4 * n + 2) * div) begin
         load = 1;
         busy = 1;
      end else if (t == (4 * n + 2) * div + 1) begin
         done = 1;
         busy = 1;
      end else begin
         rdy = 1;
      end
      return {rdy, id, phi, phib, din, load, busy, done, CW'(cnt)};
   endfunction

   task automatic chk(input string tag, input int t, input logic [14:0] o, input logic [14:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, o, e);
      end
   endtask

   task automatic chk_int(input string tag, input int o, input int e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   task automatic run_word(input string tag, input int sel, input int n, input int div,
                           input bit msb, input logic [DW-1:0] w, input int prev_cnt,
                           input bit hold, input int tail,
                           output int acc_cyc, output int waited);
      logic [14:0] o;
      int last;
      last = (4 * n + 2) * div + 1 + tail;
      tdata[sel]  = w;
      tvalid[sel] = 1'b1;
      waited = 0;
      @(negedge clk);
      o = get_obs(sel);
      while (!o[14] && waited < 100) begin
         waited++;
         @(negedge clk);
         o = get_obs(sel);
      end
      acc_cyc = cyc;
      chk({tag, "_accept"}, 0, o, model(0, n, div, w, msb, prev_cnt));
      if (waited >= 100) begin
         tvalid[sel] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (!hold) tvalid[sel] = 1'b0;
      tdata[sel] = ~w;
      for (int t = 1; t <= last; t++) begin
         @(negedge clk);
         o = get_obs(sel);
         chk(tag, t, o, model(t, n, div, w, msb, prev_cnt));
         checks++;
         assert (!(o[12] && o[11])) else begin
            errors++;
            $error("FAIL %s_overlap t=%0d observed=1 expected=0", tag, t);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int acc [3];
      int waited;
      logic [DW-1:0] w;
      logic [14:0] o;

      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         clear[i]  = 1'b0;
         tvalid[i] = 1'b0;
         tdata[i]  = '0;
      end
      w = '0;
      w[3:0] = 4'b1011;
      tdata[0]  = w;
      tvalid[0] = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) chk("reset", 0, get_obs(i), IDLE_V);

      @(posedge clk); #1;
      reset_n = 1'b1;
      run_word("basic_msb", 0, 4, 2, 1'b1, w, 0, 1'b0, 3, acc[0], waited);
      chk_int("first_accept_wait", waited, 0);

      for (int i = 0; i < 2; i++) begin
         w = {$urandom, $urandom, $urandom, $urandom};
         run_word("rand_msb", 0, 4, 2, 1'b1, w, 4, 1'b0, 2, acc[0], waited);
      end

      w = '1;
      w[3:0] = 4'b1011;
      run_word("basic_lsb", 1, 4, 2, 1'b0, w, 0, 1'b0, 3, acc[0], waited);
      for (int i = 0; i < 2; i++) begin
         w = '1;
         w[3:0] = 4'($urandom);
         run_word("rand_lsb", 1, 4, 2, 1'b0, w, 4, 1'b0, 2, acc[0], waited);
      end

      // Defaults with s_tvalid held high: back-to-back words.
      for (int i = 0; i < 3; i++) begin
         w = {$urandom, $urandom, $urandom, $urandom};
         run_word("dflt", 2, 78, 20, 1'b1, w, (i == 0) ? 0 : 78, i < 2, (i == 2) ? 2 : 0,
                  acc[i], waited);
      end
      chk_int("interval_0_1", acc[1] - acc[0], (4 * 78 + 2) * 20 + 2);
      chk_int("interval_1_2", acc[2] - acc[1], (4 * 78 + 2) * 20 + 2);

      // Abort during bit 2 (PHI of bit 2 spans cycles 19-20).
      w = {$urandom, $urandom, $urandom, $urandom};
      tdata[0]  = w;
      tvalid[0] = 1'b1;
      @(negedge clk);
      chk("abort_accept", 0, get_obs(0), model(0, 4, 2, w, 1'b1, 4));
      @(posedge clk); #1;
      tvalid[0] = 1'b0;
      for (int t = 1; t <= 19; t++) begin
         @(negedge clk);
         chk("abort_pre", t, get_obs(0), model(t, 4, 2, w, 1'b1, 4));
         @(posedge clk); #1;
      end
      clear[0] = 1'b1;
      @(negedge clk);
      chk("abort_pre", 20, get_obs(0), model(20, 4, 2, w, 1'b1, 4));
      @(posedge clk); #1;
      clear[0] = 1'b0;
      for (int t = 21; t <= 60; t++) begin
         @(negedge clk);
         chk("abort_idle", t, get_obs(0), IDLE_V);
      end

      // clear wins over a simultaneous accept.
      @(posedge clk); #1;
      tvalid[0] = 1'b1;
      clear[0]  = 1'b1;
      @(negedge clk);
      chk("clear_vs_accept", 0, get_obs(0), 15'h0000);
      @(posedge clk); #1;
      clear[0]  = 1'b0;
      tvalid[0] = 1'b0;
      @(negedge clk);
      chk("clear_vs_accept_idle", 1, get_obs(0), IDLE_V);
      @(posedge clk); #1;
      w = {$urandom, $urandom, $urandom, $urandom};
      run_word("after_abort", 0, 4, 2, 1'b1, w, 0, 1'b0, 2, acc[0], waited);

      // Asynchronous reset during LOAD (LOAD spans cycles 33-36).
      w = {$urandom, $urandom, $urandom, $urandom};
      tdata[0]  = w;
      tvalid[0] = 1'b1;
      @(negedge clk);
      chk("rst_accept", 0, get_obs(0), model(0, 4, 2, w, 1'b1, 4));
      @(posedge clk); #1;
      tvalid[0] = 1'b0;
      for (int t = 1; t <= 33; t++) begin
         @(negedge clk);
         chk("rst_pre", t, get_obs(0), model(t, 4, 2, w, 1'b1, 4));
         if (t < 33) begin
            @(posedge clk); #1;
         end
      end
      #2 reset_n = 1'b0;
      #1;
      o = get_obs(0);
      chk("rst_async", 0, o, IDLE_V);
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk);
         chk("rst_idle", t, get_obs(0), IDLE_V);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/scan_chain_loader.md
# scan_chain_loader

Serialises one parallel hop/IF code word into the tag chip's scan chain. It drives two-phase non-overlapping scan clocks (phi/phi_bar), scan_id and scan_data_in, then a scan_load_chip strobe. It sits directly downstream of the hop controller: the controller hands it a code word through a valid/ready handshake, and it returns a one-cycle done pulse. Its scan outputs are OR-ed into the front-panel GPIO output word.

## Interface
- DATA_WIDTH, 128: width of the s_tdata code bus.
- NBITS, 78: number of bits shifted per word. Must satisfy NBITS ≤ DATA_WIDTH.
- CNT_WIDTH, 7: width of bit_cnt. Must satisfy 2^CNT_WIDTH > NBITS.
- DIV, 20: length of every scan phase in clk cycles. Must satisfy DIV ≥ 2.
- MSB_FIRST, 1: 1 shifts s_tdata[NBITS-1] first; 0 shifts s_tdata[0] first.
- clk  in  1  system clock; all logic is in this single domain.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; returns the block to IDLE.
- s_tdata  in  DATA_WIDTH  code word. Bits at index NBITS and above are ignored.
- s_tvalid  in  1  code word valid.
- s_tready  out  1  high in IDLE while clear=0.
- scan_id  out  1  scan-chain select.
- scan_phi  out  1  scan clock phase 1.
- scan_phi_bar  out  1  scan clock phase 2.
- scan_data_in  out  1  serial scan data.
- scan_load_chip  out  1  parallel-load strobe to the chip.
- busy  out  1  high from accept until done, inclusive.
- done  out  1  one-cycle pulse when a word has been fully loaded.
- bit_cnt  out  CNT_WIDTH  number of bits fully clocked in (PHIB completed).

## Operation
- States: IDLE, SETUP, PHI, GAP, PHIB, LOAD, DONE.
- Accept: s_tvalid & s_tready in IDLE. The word is captured into a shift register, the phase counter is cleared, bit_cnt is cleared to 0, and the state becomes SETUP.
- Per-bit sequence: SETUP → PHI → GAP → PHIB.
  - After PHIB: if bit_cnt+1 < NBITS, go to SETUP; otherwise go to LOAD.
  - Each of SETUP, PHI, GAP and PHIB lasts exactly DIV cycles.
  - LOAD lasts 2*DIV cycles.
  - DONE lasts 1 cycle, then the state returns to IDLE.
- Outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
  - scan_id: high in SETUP/PHI/GAP/PHIB; low elsewhere.
  - scan_phi: high only in PHI.
  - scan_phi_bar: high only in PHIB.
  - scan_data_in: equals the current bit during SETUP/PHI/GAP/PHIB; 0 otherwise. The shift register advances when leaving PHIB.
  - scan_load_chip: high only in LOAD.
  - done: high only in DONE.
  - busy: high in every state except IDLE.
- Non-overlap guarantee: phi and phi_bar are never high together. Each is separated from the other by at least DIV cycles with both low (SETUP or GAP). scan_data_in is stable for the whole of PHI.
- bit_cnt increments on exit from PHIB and saturates at NBITS. It holds its value through LOAD, DONE and IDLE until the next accept.
- Phase counter: $clog2(DIV) bits wide. It counts 0..DIV-1 and wraps on the phase transition; in LOAD it counts to 2*DIV-1 (one extra bit of width).
- s_tvalid while busy is ignored and stalled (s_tready=0). A word is never lost or overwritten mid-shift.
- clear has priority over an accept in the same cycle: that word is not taken.
- clear in any state: the next state is IDLE, all scan outputs and busy go to 0, bit_cnt goes to 0, and no done pulse is generated.
- reset_n low, asynchronously: every output is 0 except s_tready, and the state is IDLE. After release, s_tready=1 (with clear=0). A reset mid-shift behaves the same way.

## Timing
- Call the handshake cycle 0. The state is SETUP from cycle 1, and scan_data_in carries the first bit from cycle 1.
- Bit k (0-based) occupies cycles 1+4kDIV through 4(k+1)DIV. Within that window, PHI is high during its second DIV cycles and PHIB during its fourth DIV cycles.
- LOAD occupies cycles 1+4·NBITS·DIV through (4·NBITS+2)·DIV.
- done is high at cycle (4·NBITS+2)·DIV+1. s_tready goes high the following cycle.
- Defaults (NBITS=78, DIV=20): done at cycle 6281; next accept possible at cycle 6282.
- Back-to-back words: the minimum accept-to-accept interval is (4·NBITS+2)·DIV+2 cycles.

## Test plan
- Reset: hold reset_n low with s_tvalid=1 → all scan outputs=0, busy=0, done=0, bit_cnt=0. One cycle after release, s_tready=1, and a word is accepted on the first valid cycle.
- Basic shift (NBITS=4, DIV=2, MSB_FIRST=1), s_tdata=4'b1011 → scan_data_in is 1,0,1,1 in the windows starting at cycles 1/9/17/25. PHI is high at cycles 3-4, 11-12, 19-20, 27-28. LOAD is high at cycles 33-36. done is high at cycle 37 only. bit_cnt ends at 4.
- LSB-first (MSB_FIRST=0), s_tdata=4'b1011 → bit order 1,1,0,1. Upper s_tdata bits set to all-ones have no effect.
- Non-overlap and stall: run the defaults with s_tvalid held high and random data → phi&phi_bar is never 1, s_tready=0 while busy, accepts occur exactly 6282 cycles apart, and every word appears on scan_data_in in the correct order.
- Abort: assert clear during bit 2 → outputs are 0 the next cycle, bit_cnt=0, there is no done pulse and no LOAD. A new word is accepted afterwards and completes normally.
- Mid-shift reset: drop reset_n asynchronously during LOAD → scan_load_chip falls immediately, done is never seen, and the state is IDLE after release.
